// File: rtl/feed_pkt_arbiter.sv
// rtl/feed_pkt_arbiter.sv - packet-atomic round-robin arbiter merging market-feed streams
module feed_pkt_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int EMPTY_WIDTH   = 3,
    parameter int MAX_PKT_BEATS = 188,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_PORTS-1:0]              in_valid,
    output logic [NUM_PORTS-1:0]              in_ready,
    input  logic [NUM_PORTS-1:0]              in_startofpacket,
    input  logic [NUM_PORTS-1:0]              in_endofpacket,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_PORTS*EMPTY_WIDTH-1:0]  in_empty,
    input  logic [NUM_PORTS-1:0]              in_error,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_startofpacket,
    output logic                              out_endofpacket,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [EMPTY_WIDTH-1:0]            out_empty,
    output logic                              out_error,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_id,
    output logic                              busy,
    output logic [CNT_WIDTH-1:0]              orphan_cnt,
    output logic [CNT_WIDTH-1:0]              trunc_cnt
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int BW = $clog2(MAX_PKT_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [GW-1:0]          r_rr_ptr;
    logic [GW-1:0]          r_grant;
    logic [BW-1:0]          r_beat_cnt;
    logic [CNT_WIDTH-1:0]   r_orphan_cnt;
    logic [CNT_WIDTH-1:0]   r_trunc_cnt;

    logic [NUM_PORTS-1:0]   w_cand;
    logic [NUM_PORTS-1:0]   w_orphan;
    logic                   w_found;
    logic [GW-1:0]          w_winner;
    logic [DATA_WIDTH-1:0]  w_data  [NUM_PORTS];
    logic [EMPTY_WIDTH-1:0] w_empty [NUM_PORTS];
    logic                   w_g_valid;
    logic                   w_g_sop;
    logic                   w_g_eop;
    logic                   w_g_err;
    logic                   w_trunc;
    logic                   w_xfer_fire;
    logic                   w_drain_fire;
    logic [GW-1:0]          w_next_ptr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign w_data[p]  = in_data[p*DATA_WIDTH +: DATA_WIDTH];
        assign w_empty[p] = in_empty[p*EMPTY_WIDTH +: EMPTY_WIDTH];
    end

    assign w_cand       = in_valid & in_startofpacket;
    assign w_orphan     = in_valid & ~in_startofpacket;
    assign w_g_valid    = in_valid[r_grant];
    assign w_g_sop      = in_startofpacket[r_grant];
    assign w_g_eop      = in_endofpacket[r_grant];
    assign w_g_err      = in_error[r_grant];
    // The last beat slot of a packet that has not ended is cut short here.
    assign w_trunc      = (r_beat_cnt == BW'(MAX_PKT_BEATS - 1)) && !w_g_eop;
    assign w_xfer_fire  = (r_state == S_XFER) && w_g_valid && out_ready;
    assign w_drain_fire = (r_state == S_DRAIN) && w_g_valid;
    assign w_next_ptr   = (r_grant == GW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;

    // Round-robin pick: first SOP candidate at or after rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            logic [GW:0] sum;
            sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
            if (sum >= (GW+1)'(NUM_PORTS)) begin
                sum = sum - (GW+1)'(NUM_PORTS);
            end
            if (!w_found && w_cand[sum[GW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = sum[GW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: packets are held atomically from grant to EOP.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_XFER;
            S_XFER: begin
                if (w_xfer_fire) begin
                    if (w_g_eop) begin
                        w_state_next = S_IDLE;
                    end else if (w_trunc) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: if (w_drain_fire && w_g_eop) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant, round-robin pointer, beat counter and saturating status counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_orphan_cnt <= '0;
            r_trunc_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((|w_orphan) && (r_orphan_cnt != '1)) begin
                        r_orphan_cnt <= r_orphan_cnt + 1'b1;
                    end
                    if (w_found) begin
                        r_grant    <= w_winner;
                        r_beat_cnt <= '0;
                    end
                end
                S_XFER: begin
                    if (w_xfer_fire) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_g_eop) begin
                            r_rr_ptr <= w_next_ptr;
                        end else if (w_trunc && (r_trunc_cnt != '1)) begin
                            r_trunc_cnt <= r_trunc_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_fire && w_g_eop) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: orphan drop in IDLE, zero-latency pass-through in XFER, sink in DRAIN.
    always_comb begin
        in_ready          = '0;
        out_valid         = 1'b0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        out_data          = '0;
        out_empty         = '0;
        out_error         = 1'b0;
        case (r_state)
            S_IDLE: in_ready = w_orphan;
            S_XFER: begin
                in_ready[r_grant] = out_ready;
                out_valid         = w_g_valid;
                out_startofpacket = w_g_sop && (r_beat_cnt == '0);
                out_endofpacket   = w_g_eop || w_trunc;
                out_data          = w_data[r_grant];
                out_empty         = w_empty[r_grant];
                out_error         = w_g_err || (w_g_sop && (r_beat_cnt != '0)) || w_trunc;
            end
            S_DRAIN: in_ready[r_grant] = 1'b1;
            default: ;
        endcase
        // Nothing is handshaken while reset is held, so no beat is lost mid-reset.
        if (!reset_n) begin
            in_ready  = '0;
            out_valid = 1'b0;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant;
    assign orphan_cnt = r_orphan_cnt;
    assign trunc_cnt  = r_trunc_cnt;

endmodule

// File: tb/tb_feed_pkt_arbiter.sv
// tb/tb_feed_pkt_arbiter.sv - self-checking bench for feed_pkt_arbiter
module tb_feed_pkt_arbiter;

    localparam int NP   = 3;
    localparam int DW   = 64;
    localparam int EW   = 3;
    localparam int MAXB = 4;
    localparam int CW   = 16;

    localparam int M_ARB     = 0;
    localparam int M_FWD     = 1;
    localparam int M_DISCARD = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     in_valid, in_ready, in_sop, in_eop, in_error;
    logic [NP*DW-1:0]  in_data;
    logic [NP*EW-1:0]  in_empty;
    logic              out_valid, out_ready, out_sop, out_eop, out_error;
    logic [DW-1:0]     out_data;
    logic [EW-1:0]     out_empty;
    logic [1:0]        grant_id;
    logic              busy;
    logic [CW-1:0]     orphan_cnt, trunc_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    feed_pkt_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW),
        .MAX_PKT_BEATS(MAXB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_data(in_data), .in_empty(in_empty), .in_error(in_error),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .out_data(out_data), .out_empty(out_empty), .out_error(out_error),
        .grant_id(grant_id), .busy(busy),
        .orphan_cnt(orphan_cnt), .trunc_cnt(trunc_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all ports; port p carries data d ^ p and empty p+1.
    task automatic put(input logic [2:0] v, input logic [2:0] s, input logic [2:0] e,
                       input logic rdy, input logic [63:0] d);
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        in_error  = '0;
        out_ready = rdy;
        for (int p = 0; p < NP; p++) begin
            in_data[p*DW +: DW]  = d ^ 64'(p);
            in_empty[p*EW +: EW] = EW'(p + 1);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       rst;
        logic [2:0] v, s, e;
        logic       rdy;
        logic       ov;
        logic [2:0] ir;
        logic       osop, oeop, oerr, bsy;
        logic [1:0] gid;
        int         ocnt, tcnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic rst, input logic [2:0] v, input logic [2:0] s,
                                input logic [2:0] e, input logic rdy, input logic ov,
                                input logic [2:0] ir, input logic osop, input logic oeop,
                                input logic oerr, input logic bsy, input logic [1:0] gid,
                                input int ocnt, input int tcnt);
        vec_t t;
        t.rst = rst; t.v = v; t.s = s; t.e = e; t.rdy = rdy; t.ov = ov; t.ir = ir;
        t.osop = osop; t.oeop = oeop; t.oerr = oerr; t.bsy = bsy; t.gid = gid;
        t.ocnt = ocnt; t.tcnt = tcnt;
        return t;
    endfunction

    // ---------------- reference model ----------------
    int          m_mode, m_ptr, m_own, m_cnt, m_orph, m_trunc;
    logic        e_ov, e_sop, e_eop, e_err;
    logic [2:0]  e_ir;
    logic [63:0] e_data;
    logic [2:0]  e_empty;

    task automatic model_reset();
        m_mode = M_ARB; m_ptr = 0; m_own = 0; m_cnt = 0; m_orph = 0; m_trunc = 0;
    endtask

    task automatic model_expect();
        bit cut;
        int g;
        g = m_own;
        e_ov = 0; e_ir = '0; e_sop = 0; e_eop = 0; e_err = 0; e_data = '0; e_empty = '0;
        if (m_mode == M_ARB) begin
            e_ir = in_valid & ~in_sop;
        end else if (m_mode == M_FWD) begin
            cut     = (m_cnt == MAXB - 1) && !in_eop[g];
            e_ov    = in_valid[g];
            e_ir[g] = out_ready;
            e_sop   = in_sop[g] && (m_cnt == 0);
            e_eop   = in_eop[g] || cut;
            e_err   = in_error[g] || (in_sop[g] && m_cnt != 0) || cut;
            e_data  = in_data[g*DW +: DW];
            e_empty = in_empty[g*EW +: EW];
        end else begin
            e_ir[g] = 1'b1;
        end
    endtask

    task automatic model_step();
        int g;
        g = m_own;
        if (m_mode == M_ARB) begin
            if (|(in_valid & ~in_sop) && m_orph < 65535) m_orph++;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_ptr + k) % NP;
                if (m_mode == M_ARB && in_valid[p] && in_sop[p]) begin
                    m_mode = M_FWD; m_own = p; m_cnt = 0;
                end
            end
        end else if (m_mode == M_FWD) begin
            if (in_valid[g] && out_ready) begin
                if (in_eop[g]) begin
                    m_mode = M_ARB; m_ptr = (g + 1) % NP;
                end else if (m_cnt == MAXB - 1) begin
                    m_mode = M_DISCARD;
                    if (m_trunc < 65535) m_trunc++;
                end
                m_cnt++;
            end
        end else begin
            if (in_valid[g] && in_eop[g]) begin
                m_mode = M_ARB; m_ptr = (g + 1) % NP;
            end
        end
    endtask

    // ---------------- random sources ----------------
    bit s_act[NP];
    int s_len[NP];
    int s_idx[NP];

    task automatic src_present(input int p);
        logic sop, eop;
        if (!s_act[p]) begin
            if ($urandom_range(0, 9) < 8) begin
                s_act[p] = 1; s_len[p] = $urandom_range(1, 6); s_idx[p] = 0;
                sop = 1'b1; eop = (s_len[p] == 1);
            end else begin
                sop = 1'b0; eop = 1'($urandom_range(0, 1));
            end
        end else begin
            sop = ($urandom_range(0, 29) == 0);
            eop = (s_idx[p] == s_len[p] - 1);
        end
        in_valid[p] = 1'b1;
        in_sop[p]   = sop;
        in_eop[p]   = eop;
        in_error[p] = ($urandom_range(0, 7) == 0);
        in_data[p*DW +: DW]  = {$urandom, $urandom};
        in_empty[p*EW +: EW] = EW'($urandom_range(0, 7));
    endtask

    initial begin
        logic [2:0] acc;

        tbl[0]  = mk(0, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 3'b001, 3'b001, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 3'b001, 3'b001, 3'b000, 1, 1, 3'b001, 1, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 3'b001, 3'b000, 3'b000, 1, 1, 3'b001, 0, 0, 0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 3'b001, 3'b000, 3'b001, 1, 1, 3'b001, 0, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 3'b010, 3'b000, 3'b000, 1, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 3'b010, 3'b000, 3'b000, 1, 0, 3'b010, 0, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 2, 0);
        tbl[9]  = mk(1, 3'b101, 3'b101, 3'b101, 1, 0, 3'b000, 0, 0, 0, 0, 0, 2, 0);
        tbl[10] = mk(1, 3'b101, 3'b101, 3'b101, 1, 1, 3'b100, 1, 1, 0, 1, 2, 2, 0);
        tbl[11] = mk(1, 3'b101, 3'b101, 3'b101, 1, 0, 3'b000, 0, 0, 0, 0, 0, 2, 0);
        tbl[12] = mk(1, 3'b101, 3'b101, 3'b101, 1, 1, 3'b001, 1, 1, 0, 1, 0, 2, 0);
        tbl[13] = mk(1, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 2, 0);
        tbl[14] = mk(1, 3'b011, 3'b010, 3'b000, 1, 0, 3'b001, 0, 0, 0, 0, 0, 2, 0);
        tbl[15] = mk(1, 3'b010, 3'b010, 3'b000, 0, 1, 3'b000, 1, 0, 0, 1, 1, 3, 0);
        tbl[16] = mk(1, 3'b010, 3'b010, 3'b000, 1, 1, 3'b010, 1, 0, 0, 1, 1, 3, 0);
        tbl[17] = mk(1, 3'b010, 3'b010, 3'b010, 1, 1, 3'b010, 0, 1, 1, 1, 1, 3, 0);
        tbl[18] = mk(1, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 3, 0);

        reset_n = 1'b0;
        put(3'b000, 3'b000, 3'b000, 1'b1, 64'h0);
        tick(); tick();

        for (int i = 0; i < 19; i++) begin
            reset_n = tbl[i].rst;
            put(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].rdy, {32'hA0, 32'(i)});
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
            chk($sformatf("tbl%0d_orphan_cnt", i), 64'(orphan_cnt), 64'(tbl[i].ocnt));
            chk($sformatf("tbl%0d_trunc_cnt", i), 64'(trunc_cnt), 64'(tbl[i].tcnt));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_sop", i), 64'(out_sop), 64'(tbl[i].osop));
                chk($sformatf("tbl%0d_eop", i), 64'(out_eop), 64'(tbl[i].oeop));
                chk($sformatf("tbl%0d_err", i), 64'(out_error), 64'(tbl[i].oerr));
                chk($sformatf("tbl%0d_data", i), out_data, {32'hA0, 32'(i)} ^ 64'(tbl[i].gid));
                chk($sformatf("tbl%0d_empty", i), 64'(out_empty), 64'(tbl[i].gid) + 64'd1);
            end
            if (tbl[i].bsy) chk($sformatf("tbl%0d_grant_id", i), 64'(grant_id), 64'(tbl[i].gid));
            tick();
        end

        // Truncation: 6-beat packet on port 0 against a 4-beat limit.
        reset_n = 1'b0;
        put(3'b000, 3'b000, 3'b000, 1'b1, 64'h0);
        tick();
        reset_n = 1'b1;
        put(3'b001, 3'b001, 3'b000, 1'b1, 64'h100);
        @(negedge clk);
        chk("tr_arb_out_valid", 64'(out_valid), 64'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            put(3'b001, (b == 0) ? 3'b001 : 3'b000, 3'b000, 1'b1, 64'h100 + 64'(b));
            @(negedge clk);
            chk($sformatf("tr_b%0d_out_valid", b), 64'(out_valid), 64'd1);
            chk($sformatf("tr_b%0d_in_ready", b), 64'(in_ready), 64'd1);
            chk($sformatf("tr_b%0d_sop", b), 64'(out_sop), 64'(b == 0));
            chk($sformatf("tr_b%0d_eop", b), 64'(out_eop), 64'(b == 3));
            chk($sformatf("tr_b%0d_err", b), 64'(out_error), 64'(b == 3));
            chk($sformatf("tr_b%0d_data", b), out_data, 64'h100 + 64'(b));
            tick();
        end
        for (int b = 4; b < 6; b++) begin
            put(3'b001, 3'b000, (b == 5) ? 3'b001 : 3'b000, 1'b1, 64'h100 + 64'(b));
            @(negedge clk);
            chk($sformatf("tr_drain%0d_out_valid", b), 64'(out_valid), 64'd0);
            chk($sformatf("tr_drain%0d_in_ready", b), 64'(in_ready), 64'd1);
            chk($sformatf("tr_drain%0d_busy", b), 64'(busy), 64'd1);
            tick();
        end
        put(3'b010, 3'b010, 3'b010, 1'b1, 64'h200);
        @(negedge clk);
        chk("tr_next_busy", 64'(busy), 64'd0);
        chk("tr_trunc_cnt", 64'(trunc_cnt), 64'd1);
        chk("tr_next_arb_in_ready", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("tr_next_out_valid", 64'(out_valid), 64'd1);
        chk("tr_next_grant_id", 64'(grant_id), 64'd1);
        chk("tr_next_eop", 64'(out_eop), 64'd1);
        chk("tr_next_err", 64'(out_error), 64'd0);
        chk("tr_next_data", out_data, 64'h201);
        tick();

        // Reset at beat 2 of a 5-beat packet on port 0.
        put(3'b001, 3'b001, 3'b000, 1'b1, 64'h300);
        tick();
        for (int b = 0; b < 2; b++) begin
            put(3'b001, (b == 0) ? 3'b001 : 3'b000, 3'b000, 1'b1, 64'h300 + 64'(b));
            @(negedge clk);
            chk($sformatf("rs_b%0d_out_valid", b), 64'(out_valid), 64'd1);
            tick();
        end
        put(3'b001, 3'b000, 3'b000, 1'b1, 64'h302);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rs_after_out_valid", 64'(out_valid), 64'd0);
        chk("rs_after_busy", 64'(busy), 64'd0);
        chk("rs_after_orphan_cnt", 64'(orphan_cnt), 64'd0);
        chk("rs_after_trunc_cnt", 64'(trunc_cnt), 64'd0);
        chk("rs_after_in_ready", 64'(in_ready), 64'd1);
        tick();
        for (int b = 3; b < 5; b++) begin
            put(3'b001, 3'b000, (b == 4) ? 3'b001 : 3'b000, 1'b1, 64'h300 + 64'(b));
            @(negedge clk);
            chk($sformatf("rs_orphan_b%0d_cnt", b), 64'(orphan_cnt), 64'(b - 2));
            chk($sformatf("rs_orphan_b%0d_in_ready", b), 64'(in_ready), 64'd1);
            tick();
        end
        put(3'b000, 3'b000, 3'b000, 1'b1, 64'h0);
        @(negedge clk);
        chk("rs_final_orphan_cnt", 64'(orphan_cnt), 64'd3);
        chk("rs_final_out_valid", 64'(out_valid), 64'd0);
        tick();

        // Randomised traffic against the reference model.
        reset_n = 1'b0;
        put(3'b000, 3'b000, 3'b000, 1'b1, 64'h0);
        tick(); tick();
        reset_n = 1'b1;
        model_reset();
        for (int p = 0; p < NP; p++) begin
            s_act[p] = 0; s_len[p] = 0; s_idx[p] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            model_expect();
            chk("rnd_out_valid", 64'(out_valid), 64'(e_ov));
            chk("rnd_in_ready", 64'(in_ready), 64'(e_ir));
            chk("rnd_busy", 64'(busy), 64'(m_mode != M_ARB));
            chk("rnd_orphan_cnt", 64'(orphan_cnt), 64'(m_orph));
            chk("rnd_trunc_cnt", 64'(trunc_cnt), 64'(m_trunc));
            if (e_ov) begin
                chk("rnd_sop", 64'(out_sop), 64'(e_sop));
                chk("rnd_eop", 64'(out_eop), 64'(e_eop));
                chk("rnd_err", 64'(out_error), 64'(e_err));
                chk("rnd_data", out_data, e_data);
                chk("rnd_empty", 64'(out_empty), 64'(e_empty));
            end
            if (m_mode != M_ARB) chk("rnd_grant_id", 64'(grant_id), 64'(m_own));
            acc = in_valid & in_ready;
            @(posedge clk);
            model_step();
            #1;
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    if (s_act[p]) begin
                        s_idx[p]++;
                        if (in_eop[p]) s_act[p] = 0;
                    end
                    in_valid[p] = 1'b0;
                end
                if (!in_valid[p] && $urandom_range(0, 9) < 6) src_present(p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
